// File: rtl/disk_ii_head_if.sv
// Signal bundle between the Disk II controller side (master) and the head
// model (slave): stepper phases, motor, latch read strobe and track RAM port.
interface disk_ii_head_if;
    logic [3:0]  phase;
    logic        motor_on;
    logic        read_strobe;
    logic [12:0] ram_read_addr;
    logic [7:0]  ram_di;
    logic [5:0]  track;
    logic [7:0]  data_latch;

    modport master (
        output phase, motor_on, read_strobe, ram_di,
        input  ram_read_addr, track, data_latch
    );

    modport slave (
        input  phase, motor_on, read_strobe, ram_di,
        output ram_read_addr, track, data_latch
    );
endinterface

// File: rtl/disk_ii_head.sv
// Disk II head model: half-track stepper with settle time, and a byte stream
// that clocks track RAM bytes into the data latch once per disk byte period.
module disk_ii_head #(
    parameter int unsigned TRACK_LEN     = 6656,
    parameter int unsigned BYTE_PERIOD   = 448,
    parameter int unsigned STEP_TICKS    = 14318,
    parameter int unsigned MAX_HALFTRACK = 68
) (
    input  logic              CLK_14M,
    input  logic              reset,
    disk_ii_head_if.slave     bus
);
    localparam logic [8:0]  BYTE_LAST = 9'(BYTE_PERIOD - 1);
    localparam logic [12:0] POS_LAST  = 13'(TRACK_LEN - 1);
    localparam logic [13:0] STEP_LOAD = 14'(STEP_TICKS - 1);
    localparam logic [6:0]  HT_MAX    = 7'(MAX_HALFTRACK);

    typedef enum logic {IDLE, SETTLE} step_state_t;

    step_state_t state;
    logic [6:0]  halftrack;
    logic [13:0] step_cnt;
    logic [8:0]  byte_cnt;
    logic [12:0] pos;
    logic [5:0]  track_q;
    logic [7:0]  latch_q;

    logic [1:0]  up_idx;
    logic [1:0]  dn_idx;
    logic        up;
    logic        dn;
    logic        load;

    // The magnets one position either side of the current half-track pull the head.
    always_comb begin
        up_idx = halftrack[1:0] + 2'd1;
        dn_idx = halftrack[1:0] + 2'd3;
        up     = bus.phase[up_idx];
        dn     = bus.phase[dn_idx];
        load   = bus.motor_on && (byte_cnt == BYTE_LAST);
    end

    always_ff @(posedge CLK_14M) begin
        if (reset) begin
            state     <= IDLE;
            halftrack <= '0;
            step_cnt  <= '0;
            byte_cnt  <= '0;
            pos       <= '0;
            track_q   <= '0;
            latch_q   <= '0;
        end else begin
            track_q <= halftrack[6:1];

            case (state)
                IDLE: begin
                    if (bus.motor_on) begin
                        if (up && !dn && halftrack != HT_MAX) begin
                            halftrack <= halftrack + 7'd1;
                            step_cnt  <= STEP_LOAD;
                            state     <= SETTLE;
                        end else if (dn && !up && halftrack != '0) begin
                            halftrack <= halftrack - 7'd1;
                            step_cnt  <= STEP_LOAD;
                            state     <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (step_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        step_cnt <= step_cnt - 14'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A load outranks a concurrent strobe so the fresh byte is never lost.
            if (bus.motor_on) begin
                if (load) begin
                    byte_cnt <= '0;
                    latch_q  <= bus.ram_di;
                    pos      <= (pos == POS_LAST) ? '0 : pos + 13'd1;
                end else begin
                    byte_cnt <= byte_cnt + 9'd1;
                    if (bus.read_strobe && latch_q[7]) begin
                        latch_q <= '0;
                    end
                end
            end
        end
    end

    assign bus.ram_read_addr = pos;
    assign bus.track         = track_q;
    assign bus.data_latch    = latch_q;
endmodule
